// File: rtl/voice_pkg.sv
// Shared constants and FSM state type for the voice mixing scheduler.
// Sine table geometry and voice count live here so all voice blocks agree.
package voice_pkg;

  localparam int NUM_VOICES   = 8;
  localparam int ADDR_WIDTH   = 8;
  localparam int SAMPLE_WIDTH = 16;
  localparam int READ_LATENCY = 2;

  localparam logic [SAMPLE_WIDTH-1:0] SINE_MIDSCALE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_NORM
  } sched_state_t;

endpackage

// File: rtl/voice_mix_scheduler_if.sv
// Frame control, sine BRAM port and mix result bundle for the scheduler.
// master = scheduler side, slave = surrounding phase/BRAM/PDM logic.
interface voice_mix_scheduler_if
  import voice_pkg::*;
#(
  parameter int NUM_VOICES   = voice_pkg::NUM_VOICES,
  parameter int ADDR_WIDTH   = voice_pkg::ADDR_WIDTH,
  parameter int SAMPLE_WIDTH = voice_pkg::SAMPLE_WIDTH
);
  logic                                sample_tick_in;
  logic [NUM_VOICES-1:0]               gate_in;
  logic [NUM_VOICES-1:0][31:0]         phase_in;
  logic [ADDR_WIDTH-1:0]               bram_addr_out;
  logic [SAMPLE_WIDTH-1:0]             bram_data_in;
  logic [SAMPLE_WIDTH-1:0]             mix_out;
  logic                                mix_valid_out;
  logic [$clog2(NUM_VOICES):0]         active_count_out;
  logic                                busy_out;
  logic                                overrun_out;

  modport master (
    input  sample_tick_in, gate_in, phase_in, bram_data_in,
    output bram_addr_out, mix_out, mix_valid_out, active_count_out, busy_out, overrun_out
  );

  modport slave (
    output sample_tick_in, gate_in, phase_in, bram_data_in,
    input  bram_addr_out, mix_out, mix_valid_out, active_count_out, busy_out, overrun_out
  );
endinterface

// File: rtl/voice_mix_scheduler_norm_shift.sv
// Maps a gated-voice count to its normalising right shift, ceil(log2(count)).
// Purely combinational; count 0 yields shift 0 (the caller substitutes midscale).
module voice_norm_shift
  import voice_pkg::*;
#(
  parameter int NUM_VOICES = voice_pkg::NUM_VOICES
) (
  input  logic [$clog2(NUM_VOICES):0] count,
  output logic [$clog2(NUM_VOICES):0] shift
);
  localparam int CW = $clog2(NUM_VOICES) + 1;

  // Descending scan leaves the smallest s with 2^s >= count.
  always_comb begin
    shift = '0;
    for (int s = CW - 1; s >= 0; s--) begin
      if ((32'd1 << s) >= 32'(count)) shift = CW'(s);
    end
  end
endmodule

// File: rtl/voice_mix_scheduler.sv
// Per sample tick: snapshot voices, read the sine BRAM once per voice, sum gated voices, normalise.
// Result 2+NUM_VOICES+READ_LATENCY cycles after the tick; ticks while busy are dropped and flagged.
module voice_mix_scheduler
  import voice_pkg::*;
#(
  parameter int NUM_VOICES   = voice_pkg::NUM_VOICES,
  parameter int ADDR_WIDTH   = voice_pkg::ADDR_WIDTH,
  parameter int SAMPLE_WIDTH = voice_pkg::SAMPLE_WIDTH,
  parameter int READ_LATENCY = voice_pkg::READ_LATENCY
) (
  input logic                  clk_in,
  input logic                  rst_in,
  voice_mix_scheduler_if.master bus
);
  localparam int IW = $clog2(NUM_VOICES);
  localparam int CW = IW + 1;
  localparam int AW = SAMPLE_WIDTH + IW;
  localparam int DW = $clog2(READ_LATENCY + 1);
  localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  sched_state_t                       state_q, state_d;
  logic [IW-1:0]                      idx_q;
  logic [DW-1:0]                      drain_q;
  logic [NUM_VOICES-1:0]              gate_snap;
  logic [NUM_VOICES-1:0][ADDR_WIDTH-1:0] addr_snap;
  logic [READ_LATENCY-1:0]            vld_pipe;
  logic [AW-1:0]                      acc_q;
  logic [CW-1:0]                      cnt_q;
  logic [CW-1:0]                      shift;
  logic                               tick_accept;
  logic                               last_voice;
  logic                               last_drain;

  assign tick_accept = (state_q == ST_IDLE) && bus.sample_tick_in;
  assign last_voice  = (idx_q == IW'(NUM_VOICES - 1));
  assign last_drain  = (drain_q == DW'(READ_LATENCY - 1));

  voice_norm_shift #(.NUM_VOICES(NUM_VOICES)) u_norm_shift (
    .count (cnt_q),
    .shift (shift)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (tick_accept) state_d = ST_ISSUE;
      ST_ISSUE: if (last_voice)  state_d = ST_DRAIN;
      ST_DRAIN: if (last_drain)  state_d = ST_NORM;
      ST_NORM:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx_q                <= '0;
      drain_q              <= '0;
      gate_snap            <= '0;
      addr_snap            <= '0;
      vld_pipe             <= '0;
      acc_q                <= '0;
      cnt_q                <= '0;
      bus.bram_addr_out    <= '0;
      bus.mix_out          <= MIDSCALE;
      bus.mix_valid_out    <= 1'b0;
      bus.active_count_out <= '0;
      bus.busy_out         <= 1'b0;
      bus.overrun_out      <= 1'b0;
    end else begin
      bus.mix_valid_out <= 1'b0;
      bus.overrun_out   <= bus.sample_tick_in && (state_q != ST_IDLE);
      bus.busy_out      <= (state_d != ST_IDLE);
      bus.bram_addr_out <= '0;
      vld_pipe          <= vld_pipe << 1;

      // Oldest pipe bit lines up with the BRAM word for the voice it was pushed with.
      if (vld_pipe[READ_LATENCY-1]) begin
        acc_q <= acc_q + AW'(bus.bram_data_in);
        cnt_q <= cnt_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (tick_accept) begin
            gate_snap <= bus.gate_in;
            for (int i = 0; i < NUM_VOICES; i++) begin
              addr_snap[i] <= bus.phase_in[i][31 -: ADDR_WIDTH];
            end
            acc_q             <= '0;
            cnt_q             <= '0;
            idx_q             <= '0;
            bus.bram_addr_out <= bus.phase_in[0][31 -: ADDR_WIDTH];
          end
        end
        ST_ISSUE: begin
          vld_pipe <= (vld_pipe << 1) | READ_LATENCY'(gate_snap[idx_q]);
          idx_q    <= idx_q + 1'b1;
          drain_q  <= '0;
          if (!last_voice) bus.bram_addr_out <= addr_snap[idx_q + 1'b1];
        end
        ST_DRAIN: drain_q <= drain_q + 1'b1;
        ST_NORM: begin
          bus.mix_out          <= (cnt_q == '0) ? MIDSCALE : SAMPLE_WIDTH'(acc_q >> shift);
          bus.active_count_out <= cnt_q;
          bus.mix_valid_out    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Directed bench: a driver pushes expected frame results, a monitor pops them on mix_valid_out.
// BRAM model has two-cycle read latency and returns either addr*256 or all-ones.
module tb_voice_mix_scheduler;
  import voice_pkg::*;

  typedef struct {
    logic [15:0] mix;
    logic [3:0]  cnt;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   mode_ones = 1'b0;
  logic [7:0] a1 = '0;
  logic [7:0] a2 = '0;
  exp_t sb[$];

  voice_mix_scheduler_if bus ();

  voice_mix_scheduler dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    a1 <= bus.bram_addr_out;
    a2 <= a1;
  end
  always_comb bus.bram_data_in = mode_ones ? 16'hFFFF : {a2, 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mix_valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got pulse with no frame pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mix_out", 32'(bus.mix_out), 32'(e.mix));
        check("active_count", 32'(bus.active_count_out), 32'(e.cnt));
        check("valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Assumes caller is just after a rising edge; returns in the following cycle.
  task automatic do_tick(input logic [7:0] g, output int t);
    bus.gate_in        = g;
    bus.sample_tick_in = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    bus.sample_tick_in = 1'b0;
  endtask

  task automatic expect_frame(input logic [15:0] m, input logic [3:0] c, input int t);
    exp_t e;
    e.mix = m;
    e.cnt = c;
    e.cyc = t + 12;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.sample_tick_in = 1'b0;
    bus.gate_in        = '0;
    for (int i = 0; i < 8; i++) bus.phase_in[i] = {4'(i), 28'h0};
    bus.phase_in[0] = 32'h4000_0000;
    bus.phase_in[1] = 32'hA512_3456;

    wait_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mix", 32'(bus.mix_out), 32'(SINE_MIDSCALE));
    check("rst_valid", 32'(bus.mix_valid_out), 0);
    check("rst_busy", 32'(bus.busy_out), 0);
    check("rst_overrun", 32'(bus.overrun_out), 0);
    check("rst_count", 32'(bus.active_count_out), 0);
    check("rst_addr", 32'(bus.bram_addr_out), 0);
    wait_cycles(1);

    // Single voice: 0x40 * 256 = 0x4000, shift 0.
    mode_ones = 1'b0;
    do_tick(8'h01, t);
    expect_frame(16'h4000, 4'd1, t);
    @(negedge clk);
    check("addr_v0", 32'(bus.bram_addr_out), 32'h40);
    check("busy_t1", 32'(bus.busy_out), 1);
    wait_cycles(1);
    @(negedge clk);
    check("addr_v1", 32'(bus.bram_addr_out), 32'hA5);
    wait_cycles(13);
    @(negedge clk);
    check("busy_idle", 32'(bus.busy_out), 0);
    check("addr_idle", 32'(bus.bram_addr_out), 0);
    wait_cycles(1);

    // Full chord: 8 * 0xFFFF = 0x7FFF8, >> 3 = 0xFFFF.
    mode_ones = 1'b1;
    do_tick(8'hFF, t);
    expect_frame(16'hFFFF, 4'd8, t);
    wait_cycles(14);

    // Three voices: 0x2FFFD >> 2 = 0xBFFF.
    do_tick(8'h07, t);
    expect_frame(16'hBFFF, 4'd3, t);
    wait_cycles(14);

    // Silence yields midscale with a valid pulse.
    do_tick(8'h00, t);
    expect_frame(16'h8000, 4'd0, t);
    wait_cycles(14);

    // Overrun plus snapshot: gate changed mid-frame must not affect the result.
    mode_ones = 1'b0;
    do_tick(8'h01, t);
    expect_frame(16'h4000, 4'd1, t);
    wait_cycles(2);
    bus.gate_in = 8'hFF;
    wait_cycles(2);
    bus.sample_tick_in = 1'b1;
    @(negedge clk);
    check("ovr_before", 32'(bus.overrun_out), 0);
    @(posedge clk);
    #1;
    bus.sample_tick_in = 1'b0;
    @(negedge clk);
    check("ovr_pulse", 32'(bus.overrun_out), 1);
    wait_cycles(1);
    @(negedge clk);
    check("ovr_after", 32'(bus.overrun_out), 0);
    wait_cycles(10);

    // Reset mid-frame aborts without a valid pulse.
    mode_ones = 1'b1;
    do_tick(8'hFF, t);
    wait_cycles(5);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy_out), 0);
    check("abort_mix", 32'(bus.mix_out), 32'h8000);
    check("abort_valid", 32'(bus.mix_valid_out), 0);
    wait_cycles(12);
    do_tick(8'h07, t);
    expect_frame(16'hBFFF, 4'd3, t);
    wait_cycles(14);

    // Back-to-back: tick coincident with mix_valid_out is accepted.
    mode_ones = 1'b0;
    bus.gate_in = 8'h01;
    do_tick(8'h01, t);
    expect_frame(16'h4000, 4'd1, t);
    wait_cycles(11);
    do_tick(8'h01, t);
    expect_frame(16'h4000, 4'd1, t);
    @(negedge clk);
    check("b2b_no_ovr", 32'(bus.overrun_out), 0);
    check("b2b_busy", 32'(bus.busy_out), 1);
    wait_cycles(16);

    check("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
